// File: rtl/bram_stream_loader_pkg.sv
// Shared definitions for the BRAM stream loader: bus widths, FSM states and the
// byte-lane write-enable helper.
package bram_stream_loader_pkg;

    localparam int unsigned BRAM_AW    = 32;
    localparam int unsigned BRAM_DW    = 32;
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Write-enable mask covering lanes 0..last_lane (3 gives a full word).
    function automatic logic [WORD_BYTES-1:0] lane_mask(input logic [1:0] last_lane);
        logic [WORD_BYTES-1:0] m;
        for (int unsigned k = 0; k < WORD_BYTES; k++) begin
            m[k] = (k <= 32'(last_lane));
        end
        return m;
    endfunction

endpackage

// File: rtl/bram_stream_loader.sv
// Byte-stream to BRAM writer: packs bytes little-endian into 32-bit words and writes
// them at consecutive word-aligned addresses, framed by a start/done handshake.
module bram_stream_loader
    import bram_stream_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BRAM_AW-1:0]    base_addr,
    input  logic [LEN_W-1:0]      len_bytes,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BRAM_AW-1:0]    BRAM_ADDR,
    output logic                  BRAM_EN,
    output logic [WORD_BYTES-1:0] BRAM_WE,
    output logic [BRAM_DW-1:0]    BRAM_DIN,
    input  logic [BRAM_DW-1:0]    BRAM_DOUT
);

    localparam int unsigned      IDX_W   = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DEPTH);

    state_e                       state_q;
    logic [LEN_W-1:0]             rem_q;
    logic [1:0]                   lane_q;
    logic [WORD_BYTES-1:0][7:0]   lanes_q;
    logic [IDX_W-1:0]             widx_q;
    logic                         ready_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         err_q;
    logic                         en_q;
    logic [WORD_BYTES-1:0]        we_q;
    logic [BRAM_AW-1:0]           addr_q;
    logic [BRAM_DW-1:0]           din_q;

    logic [WORD_BYTES-1:0][7:0]   word_d;
    logic                         last_byte_d;
    logic                         dout_unused;

    // The word as it will look once the incoming byte lands in the current lane.
    always_comb begin
        word_d         = lanes_q;
        word_d[lane_q] = s_data;
        last_byte_d    = (lane_q == 2'd3) || (rem_q == LEN_W'(1));
    end

    assign dout_unused = ^BRAM_DOUT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            lane_q  <= '0;
            lanes_q <= '0;
            widx_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            done_q <= 1'b0;
            en_q   <= 1'b0;
            we_q   <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr & ~BRAM_AW'(3);
                        rem_q   <= len_bytes;
                        lane_q  <= '0;
                        lanes_q <= '0;
                        widx_q  <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (len_bytes == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_FILL;
                            ready_q <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (s_valid) begin
                        lanes_q <= word_d;
                        lane_q  <= lane_q + 2'd1;
                        rem_q   <= rem_q - LEN_W'(1);
                        if (last_byte_d) begin
                            state_q <= ST_WRITE;
                            ready_q <= 1'b0;
                            din_q   <= word_d;
                            // Words past the BRAM end are still consumed, just not written.
                            if (widx_q < IDX_MAX) begin
                                en_q <= 1'b1;
                                we_q <= lane_mask(lane_q);
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    addr_q  <= addr_q + BRAM_AW'(WORD_BYTES);
                    lanes_q <= '0;
                    lane_q  <= '0;
                    if (widx_q != IDX_MAX) begin
                        widx_q <= widx_q + IDX_W'(1);
                    end
                    if (rem_q != '0) begin
                        state_q <= ST_FILL;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready   = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign BRAM_ADDR = addr_q;
    assign BRAM_EN   = en_q;
    assign BRAM_WE   = we_q;
    assign BRAM_DIN  = din_q;

endmodule

// File: tb/tb_bram_stream_loader.sv
// Self-checking bench for bram_stream_loader: vector table, hand-written corner cases
// and randomized loads checked against a word-level model of the expected BRAM writes.
module tb_bram_stream_loader;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      base_addr;
    logic [LEN_W-1:0] len_bytes;
    logic             s_valid;
    logic [7:0]       s_data;
    logic             s_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [31:0]      BRAM_ADDR;
    logic             BRAM_EN;
    logic [3:0]       BRAM_WE;
    logic [31:0]      BRAM_DIN;
    logic [31:0]      BRAM_DOUT;

    bram_stream_loader #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len_bytes (len_bytes),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .BRAM_ADDR (BRAM_ADDR),
        .BRAM_EN   (BRAM_EN),
        .BRAM_WE   (BRAM_WE),
        .BRAM_DIN  (BRAM_DIN),
        .BRAM_DOUT (BRAM_DOUT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] din;
        int          cyc;
    } wr_t;

    logic [31:0] mem [0:255];
    wr_t         wr_q[$];
    int          cyc_n     = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    int          ready_bad = 0;
    int          we_bad    = 0;

    assign BRAM_DOUT = mem[BRAM_ADDR[9:2]];

    // BRAM model and bus monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (cyc_n == 0) begin
            for (int w = 0; w < 256; w++) mem[w] = 32'hDEAD_0000 | 32'(w);
        end
        cyc_n++;
        if (BRAM_EN === 1'b1) begin
            wr_q.push_back('{BRAM_ADDR, BRAM_WE, BRAM_DIN, cyc_n});
            for (int b = 0; b < 4; b++) begin
                if (BRAM_WE[b]) mem[BRAM_ADDR[9:2]][8*b +: 8] = BRAM_DIN[8*b +: 8];
            end
            if (s_ready !== 1'b0) ready_bad++;
        end else if (BRAM_WE !== 4'h0) begin
            we_bad++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          wr0   = 0;
    logic [7:0]  bytes_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_load(input logic [31:0] base, input int unsigned len,
                            input int unsigned gap, input bit repulse);
        int unsigned idx   = 0;
        int unsigned guard = 0;
        bit          acc;
        int          d0;
        wr0 = wr_q.size();
        d0  = done_cnt;
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        len_bytes = LEN_W'(len);
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 32'hFFFF_FFFF;
        len_bytes = '1;
        while (idx < len && guard < 400) begin
            case (gap)
                0:       s_valid = 1'b1;
                1:       s_valid = (guard % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data = bytes_q[idx];
            if (repulse && guard == 5) begin
                start     = 1'b1;
                base_addr = 32'h200;
                len_bytes = LEN_W'(1);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            acc = s_valid && (s_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        start   = 1'b0;
        check("bytes_accepted", idx, len);
        guard = 0;
        while (done_cnt == d0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
    endtask

    // Expected writes from the load rules: word w covers bytes 4w..4w+3, dropped past DEPTH.
    task automatic check_model(input logic [31:0] base, input int unsigned len);
        int unsigned nw = (len + 3) / 4;
        int          k  = 0;
        logic [31:0] din;
        logic [3:0]  we;
        for (int unsigned w = 0; w < nw; w++) begin
            if (w >= DEPTH) continue;
            din = '0;
            we  = '0;
            for (int unsigned b = 0; b < 4; b++) begin
                if (4*w + b < len) begin
                    din[8*b +: 8] = bytes_q[4*w + b];
                    we[b]         = 1'b1;
                end
            end
            if (wr0 + k < wr_q.size()) begin
                check($sformatf("addr[%0d]", w), wr_q[wr0+k].addr, (base & ~32'h3) + 32'(4*w));
                check($sformatf("we[%0d]", w), 32'(wr_q[wr0+k].we), 32'(we));
                check($sformatf("din[%0d]", w), wr_q[wr0+k].din, din);
            end
            k++;
        end
        check("n_writes", 32'(wr_q.size() - wr0), 32'(k));
        check("err_flag", 32'(err), 32'(nw > DEPTH));
        if (k > 0 && nw <= DEPTH && wr_q.size() > 0) begin
            check("done_after_write", 32'(done_cyc - wr_q[wr_q.size()-1].cyc), 32'd1);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        int unsigned len;
        logic [7:0]  seed;
        int unsigned gap;
        bit          repulse;
        int unsigned exp_wr;
        bit          exp_err;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vt[8];

    initial begin
        int          n0;
        int          g;
        int unsigned idx;
        bit          acc;
        logic [31:0] rbase;
        int unsigned rlen;
        int unsigned rgap;

        vt[0] = '{32'h0000_0000,  8, 8'h01, 0, 1'b0, 2, 1'b0, 4'hF, 32'h0000_0000 + 32'h4};
        vt[1] = '{32'h0000_0040,  5, 8'hA0, 0, 1'b0, 2, 1'b0, 4'h1, 32'h0000_0044};
        vt[2] = '{32'h0000_0103,  3, 8'h10, 0, 1'b0, 1, 1'b0, 4'h7, 32'h0000_0100};
        vt[3] = '{32'h0000_0020,  6, 8'h30, 2, 1'b0, 2, 1'b0, 4'h3, 32'h0000_0024};
        vt[4] = '{32'h0000_0000, 12, 8'h50, 0, 1'b0, 2, 1'b1, 4'hF, 32'h0000_0004};
        vt[5] = '{32'h0000_0080,  4, 8'h60, 0, 1'b0, 1, 1'b0, 4'hF, 32'h0000_0080};
        vt[6] = '{32'h0000_0000,  8, 8'h01, 1, 1'b1, 2, 1'b0, 4'hF, 32'h0000_0004};
        vt[7] = '{32'h0000_0010,  7, 8'h70, 2, 1'b0, 2, 1'b0, 4'h7, 32'h0000_0014};

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0;
        base_addr = '0; len_bytes = '0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_en", 32'(BRAM_EN), 32'd0);
        check("rst_we", 32'(BRAM_WE), 32'd0);
        check("rst_addr", BRAM_ADDR, 32'd0);
        check("rst_din", BRAM_DIN, 32'd0);
        rst = 1'b0;

        // Eight bytes back-to-back: two full words, 5-cycle cadence, done right after.
        bytes_q.delete();
        for (int j = 0; j < 8; j++) bytes_q.push_back(8'(j + 1));
        run_load(32'h0, 8, 0, 1'b0);
        check_model(32'h0, 8);
        if (wr_q.size() - wr0 >= 2) begin
            check("t1_din0", wr_q[wr0].din, 32'h0403_0201);
            check("t1_din1", wr_q[wr0+1].din, 32'h0807_0605);
            check("t1_addr1", wr_q[wr0+1].addr, 32'h4);
            check("t1_cadence", 32'(wr_q[wr0+1].cyc - wr_q[wr0].cyc), 32'd5);
        end

        for (int i = 0; i < 8; i++) begin
            bytes_q.delete();
            for (int unsigned j = 0; j < vt[i].len; j++) bytes_q.push_back(vt[i].seed + 8'(j));
            run_load(vt[i].base, vt[i].len, vt[i].gap, vt[i].repulse);
            check_model(vt[i].base, vt[i].len);
            check($sformatf("tbl%0d_nwr", i), 32'(wr_q.size() - wr0), 32'(vt[i].exp_wr));
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(vt[i].exp_err));
            if (wr_q.size() > wr0) begin
                check($sformatf("tbl%0d_last_we", i), 32'(wr_q[wr_q.size()-1].we), 32'(vt[i].exp_we));
                check($sformatf("tbl%0d_last_addr", i), wr_q[wr_q.size()-1].addr, vt[i].exp_addr);
            end
        end
        check("ready_low_in_write", 32'(ready_bad), 32'd0);
        check("mem_word10", mem[8'h10], 32'hA3A2_A1A0);
        check("mem_word11_partial", mem[8'h11], 32'hDEAD_00A4);

        // Zero-length load: done and busy for exactly the cycle after start, no write.
        n0 = wr_q.size();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h0; len_bytes = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("len0_done_end", 32'(done), 32'd0);
        check("len0_busy_end", 32'(busy), 32'd0);
        check("len0_no_write", 32'(wr_q.size() - n0), 32'd0);

        // Reset after six of eight bytes: first word written, partial second word lost.
        bytes_q.delete();
        for (int j = 0; j < 8; j++) bytes_q.push_back(8'(j + 1));
        n0 = wr_q.size();
        @(posedge clk); #1;
        start = 1'b1; base_addr = 32'h0; len_bytes = LEN_W'(8);
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0; g = 0;
        while (idx < 6 && g < 50) begin
            s_valid = 1'b1;
            s_data  = bytes_q[idx];
            @(negedge clk);
            acc = (s_ready === 1'b1);
            @(posedge clk); #1;
            if (acc) idx++;
            g++;
        end
        s_valid = 1'b0;
        check("mid_bytes_fed", idx, 32'd6);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(s_ready), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_en", 32'(BRAM_EN), 32'd0);
        check("mid_rst_addr", BRAM_ADDR, 32'd0);
        check("mid_rst_din", BRAM_DIN, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_writes", 32'(wr_q.size() - n0), 32'd1);
        run_load(32'h0, 8, 0, 1'b0);
        check_model(32'h0, 8);

        for (int r = 0; r < 20; r++) begin
            rlen  = $urandom_range(0, 14);
            rbase = $urandom;
            rgap  = $urandom_range(0, 2);
            bytes_q.delete();
            for (int unsigned j = 0; j < rlen; j++) bytes_q.push_back(8'($urandom));
            run_load(rbase, rlen, rgap, 1'b0);
            check_model(rbase, rlen);
        end
        check("ready_low_in_write_all", 32'(ready_bad), 32'd0);
        check("we_zero_outside_write", 32'(we_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
